// File: rtl/alu_issue_stage.sv
// Decode/issue stage for the scalar ALU: decodes RV64 OP/OP-IMM/OP-32/OP-IMM-32
// into an ALU op code and operands, and presents them through a registered skid-buffered handshake.
module alu_issue_stage #(
    parameter int XLEN = 64,
    parameter int OP_W = 7
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       instr_i,
    input  logic [XLEN-1:0]   data_rs1_i,
    input  logic [XLEN-1:0]   data_rs2_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OP_W-1:0]   instr_type_o,
    output logic [XLEN-1:0]   data_rs1_o,
    output logic [XLEN-1:0]   data_rs2_o,
    output logic [4:0]        rd_addr_o,
    output logic              illegal_o
);

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    localparam logic [OP_W-1:0] ALU_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] ALU_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] ALU_ADDW = OP_W'(2);
    localparam logic [OP_W-1:0] ALU_SUBW = OP_W'(3);
    localparam logic [OP_W-1:0] ALU_XOR  = OP_W'(4);
    localparam logic [OP_W-1:0] ALU_OR   = OP_W'(5);
    localparam logic [OP_W-1:0] ALU_AND  = OP_W'(6);
    localparam logic [OP_W-1:0] ALU_SRA  = OP_W'(7);
    localparam logic [OP_W-1:0] ALU_SRL  = OP_W'(8);
    localparam logic [OP_W-1:0] ALU_SLL  = OP_W'(9);
    localparam logic [OP_W-1:0] ALU_SRLW = OP_W'(10);
    localparam logic [OP_W-1:0] ALU_SLLW = OP_W'(11);
    localparam logic [OP_W-1:0] ALU_SRAW = OP_W'(12);
    localparam logic [OP_W-1:0] ALU_SLT  = OP_W'(21);
    localparam logic [OP_W-1:0] ALU_SLTU = OP_W'(22);

    typedef struct packed {
        logic              illegal;
        logic [OP_W-1:0]   op;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [4:0]        rd;
    } uop_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] shamt6;
    logic [XLEN-1:0] shamt5;
    logic            unused_rs1_field;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign funct7   = instr_i[31:25];
    assign imm_sext = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign shamt6   = {{(XLEN-6){1'b0}}, instr_i[25:20]};
    assign shamt5   = {{(XLEN-5){1'b0}}, instr_i[24:20]};
    // rs1 index is resolved by the register file upstream; only its data arrives here.
    assign unused_rs1_field = ^instr_i[19:15];

    logic            dec_legal;
    logic [OP_W-1:0] dec_op;
    logic [XLEN-1:0] dec_op2;
    uop_t            dec_uop;

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = ALU_ADD;
        dec_op2   = data_rs2_i;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'd0:    dec_op = ALU_ADD;
                        3'd1:    dec_op = ALU_SLL;
                        3'd2:    dec_op = ALU_SLT;
                        3'd3:    dec_op = ALU_SLTU;
                        3'd4:    dec_op = ALU_XOR;
                        3'd5:    dec_op = ALU_SRL;
                        3'd6:    dec_op = ALU_OR;
                        default: dec_op = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'd0) begin
                        dec_legal = 1'b1;
                        dec_op    = ALU_SUB;
                    end else if (funct3 == 3'd5) begin
                        dec_legal = 1'b1;
                        dec_op    = ALU_SRA;
                    end
                end
            end
            OPC_OP_IMM: begin
                dec_op2 = imm_sext;
                case (funct3)
                    3'd0: begin dec_legal = 1'b1; dec_op = ALU_ADD;  end
                    3'd2: begin dec_legal = 1'b1; dec_op = ALU_SLT;  end
                    3'd3: begin dec_legal = 1'b1; dec_op = ALU_SLTU; end
                    3'd4: begin dec_legal = 1'b1; dec_op = ALU_XOR;  end
                    3'd6: begin dec_legal = 1'b1; dec_op = ALU_OR;   end
                    3'd7: begin dec_legal = 1'b1; dec_op = ALU_AND;  end
                    3'd1: begin
                        dec_op2 = shamt6;
                        if (instr_i[31:26] == 6'b000000) begin
                            dec_legal = 1'b1;
                            dec_op    = ALU_SLL;
                        end
                    end
                    default: begin
                        dec_op2 = shamt6;
                        if (instr_i[31:26] == 6'b000000) begin
                            dec_legal = 1'b1;
                            dec_op    = ALU_SRL;
                        end else if (instr_i[31:26] == 6'b010000) begin
                            dec_legal = 1'b1;
                            dec_op    = ALU_SRA;
                        end
                    end
                endcase
            end
            OPC_OP_32: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'd0: begin dec_legal = 1'b1; dec_op = ALU_ADDW; end
                        3'd1: begin dec_legal = 1'b1; dec_op = ALU_SLLW; end
                        3'd5: begin dec_legal = 1'b1; dec_op = ALU_SRLW; end
                        default: dec_legal = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    case (funct3)
                        3'd0: begin dec_legal = 1'b1; dec_op = ALU_SUBW; end
                        3'd5: begin dec_legal = 1'b1; dec_op = ALU_SRAW; end
                        default: dec_legal = 1'b0;
                    endcase
                end
            end
            OPC_OP_IMM_32: begin
                case (funct3)
                    3'd0: begin
                        dec_legal = 1'b1;
                        dec_op    = ALU_ADDW;
                        dec_op2   = imm_sext;
                    end
                    3'd1: begin
                        dec_op2 = shamt5;
                        if (funct7 == 7'b0000000) begin
                            dec_legal = 1'b1;
                            dec_op    = ALU_SLLW;
                        end
                    end
                    3'd5: begin
                        dec_op2 = shamt5;
                        if (funct7 == 7'b0000000) begin
                            dec_legal = 1'b1;
                            dec_op    = ALU_SRLW;
                        end else if (funct7 == 7'b0100000) begin
                            dec_legal = 1'b1;
                            dec_op    = ALU_SRAW;
                        end
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase

        // Illegal words travel downstream flagged, with every payload field zeroed.
        dec_uop = '0;
        if (dec_legal) begin
            dec_uop.op  = dec_op;
            dec_uop.op1 = data_rs1_i;
            dec_uop.op2 = dec_op2;
            dec_uop.rd  = instr_i[11:7];
        end else begin
            dec_uop.illegal = 1'b1;
        end
    end

    logic out_valid_reg;
    logic skid_valid_reg;
    uop_t out_reg;
    uop_t skid_reg;
    logic accept;
    logic out_free;

    assign accept   = in_valid_i & ~skid_valid_reg;
    assign out_free = ~out_valid_reg | out_ready_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            out_reg        <= '0;
            skid_reg       <= '0;
        end else if (flush_i) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (out_free) begin
            // The skid entry is older than anything on the input, so it goes first.
            if (skid_valid_reg) begin
                out_reg        <= skid_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else if (accept) begin
                out_reg        <= dec_uop;
                out_valid_reg  <= 1'b1;
            end else begin
                out_valid_reg  <= 1'b0;
            end
        end else if (accept) begin
            skid_reg       <= dec_uop;
            skid_valid_reg <= 1'b1;
        end
    end

    assign in_ready_o   = ~skid_valid_reg;
    assign out_valid_o  = out_valid_reg;
    assign instr_type_o = out_reg.op;
    assign data_rs1_o   = out_reg.op1;
    assign data_rs2_o   = out_reg.op2;
    assign rd_addr_o    = out_reg.rd;
    assign illegal_o    = out_reg.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, back-pressure ordering, flush and async reset.
module tb_alu_issue_stage;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [63:0] data_rs1_i;
    logic [63:0] data_rs2_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [6:0]  instr_type_o;
    logic [63:0] data_rs1_o;
    logic [63:0] data_rs2_o;
    logic [4:0]  rd_addr_o;
    logic        illegal_o;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.XLEN(64), .OP_W(7)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .instr_i      (instr_i),
        .data_rs1_i   (data_rs1_i),
        .data_rs2_i   (data_rs2_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .instr_type_o (instr_type_o),
        .data_rs1_o   (data_rs1_o),
        .data_rs2_o   (data_rs2_o),
        .rd_addr_o    (rd_addr_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
        in_valid_i = 1'b1;
        instr_i    = ins;
        data_rs1_i = a;
        data_rs2_i = b;
    endtask

    // Offer one instruction for one cycle with out_ready_i held high.
    task automatic issue(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
        drive(ins, a, b);
        tick();
        in_valid_i = 1'b0;
    endtask

    initial begin
        rstn_i      = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        instr_i     = 32'h0;
        data_rs1_i  = 64'h0;
        data_rs2_i  = 64'h0;
        out_ready_i = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_in_ready",  64'(in_ready_o),  64'd1);
        check("rst_rs1",       data_rs1_o,       64'd0);
        check("rst_type",      64'(instr_type_o), 64'd0);
        rstn_i = 1'b1;
        tick();

        // ADD x3,x1,x2
        issue(r_type(7'b0000000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011), 64'd5, 64'd7);
        check("add_valid", 64'(out_valid_o), 64'd1);
        check("add_type",  64'(instr_type_o), 64'd0);
        check("add_rs1",   data_rs1_o, 64'd5);
        check("add_rs2",   data_rs2_o, 64'd7);
        check("add_rd",    64'(rd_addr_o), 64'd3);
        check("add_ill",   64'(illegal_o), 64'd0);

        // ADDI x4,x1,-1
        issue(i_type(12'hFFF, 5'd1, 3'd0, 5'd4, 7'b0010011), 64'd1, 64'h1234);
        check("addi_type", 64'(instr_type_o), 64'd0);
        check("addi_rs1",  data_rs1_o, 64'd1);
        check("addi_rs2",  data_rs2_o, 64'hFFFF_FFFF_FFFF_FFFF);

        // SRAI x5,x1,63
        issue(i_type({6'b010000, 6'd63}, 5'd1, 3'd5, 5'd5, 7'b0010011), 64'd9, 64'h55);
        check("srai_type", 64'(instr_type_o), 64'd7);
        check("srai_rs2",  data_rs2_o, 64'd63);

        // SRAIW x6,x1,31
        issue(i_type({7'b0100000, 5'd31}, 5'd1, 3'd5, 5'd6, 7'b0011011), 64'd9, 64'h55);
        check("sraiw_type", 64'(instr_type_o), 64'd12);
        check("sraiw_rs2",  data_rs2_o, 64'd31);

        // SUB x7,x1,x2 and SLTU x8,x1,x2
        issue(r_type(7'b0100000, 5'd2, 5'd1, 3'd0, 5'd7, 7'b0110011), 64'd20, 64'd3);
        check("sub_type", 64'(instr_type_o), 64'd1);
        check("sub_rd",   64'(rd_addr_o), 64'd7);
        issue(r_type(7'b0000000, 5'd2, 5'd1, 3'd3, 5'd8, 7'b0110011), 64'd20, 64'd3);
        check("sltu_type", 64'(instr_type_o), 64'd22);

        // SLLW register form keeps rs2 data
        issue(r_type(7'b0000000, 5'd2, 5'd1, 3'd1, 5'd9, 7'b0111011), 64'd1, 64'hABCD);
        check("sllw_type", 64'(instr_type_o), 64'd11);
        check("sllw_rs2",  data_rs2_o, 64'hABCD);

        // MUL is not handled here
        issue(r_type(7'b0000001, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011), 64'd5, 64'd7);
        check("mul_valid", 64'(out_valid_o), 64'd1);
        check("mul_ill",   64'(illegal_o), 64'd1);
        check("mul_type",  64'(instr_type_o), 64'd0);
        check("mul_rs1",   data_rs1_o, 64'd0);
        check("mul_rs2",   data_rs2_o, 64'd0);
        check("mul_rd",    64'(rd_addr_o), 64'd0);

        // SLLIW with instr[25]=1
        issue(i_type({7'b0000001, 5'd3}, 5'd1, 3'd1, 5'd3, 7'b0011011), 64'd5, 64'd7);
        check("slliw_ill", 64'(illegal_o), 64'd1);
        check("slliw_rs2", data_rs2_o, 64'd0);
        tick();
        check("idle_valid", 64'(out_valid_o), 64'd0);

        // Back-pressure: three back-to-back instructions with out_ready_i low
        out_ready_i = 1'b0;
        drive(r_type(7'b0, 5'd2, 5'd1, 3'd0, 5'd1, 7'b0110011), 64'd11, 64'd1);
        tick();
        check("bp_ready_1", 64'(in_ready_o), 64'd1);
        drive(r_type(7'b0, 5'd2, 5'd1, 3'd0, 5'd2, 7'b0110011), 64'd22, 64'd2);
        tick();
        check("bp_ready_2", 64'(in_ready_o), 64'd0);
        check("bp_hold_rd", 64'(rd_addr_o), 64'd1);
        drive(r_type(7'b0, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011), 64'd33, 64'd3);
        tick();
        tick();
        check("bp_stable_rd",  64'(rd_addr_o), 64'd1);
        check("bp_stable_rs1", data_rs1_o, 64'd11);
        check("bp_stable_rdy", 64'(in_ready_o), 64'd0);
        out_ready_i = 1'b1;
        tick();
        check("bp_out2_rd",  64'(rd_addr_o), 64'd2);
        check("bp_out2_rs1", data_rs1_o, 64'd22);
        check("bp_out2_rdy", 64'(in_ready_o), 64'd1);
        tick();
        in_valid_i = 1'b0;
        check("bp_out3_rd",  64'(rd_addr_o), 64'd3);
        check("bp_out3_rs1", data_rs1_o, 64'd33);
        check("bp_out3_vld", 64'(out_valid_o), 64'd1);
        tick();
        check("bp_drained", 64'(out_valid_o), 64'd0);

        // Flush with output and skid both full and a new input presented
        out_ready_i = 1'b0;
        drive(r_type(7'b0, 5'd2, 5'd1, 3'd0, 5'd4, 7'b0110011), 64'd44, 64'd4);
        tick();
        drive(r_type(7'b0, 5'd2, 5'd1, 3'd0, 5'd5, 7'b0110011), 64'd55, 64'd5);
        tick();
        check("fl_full_rdy", 64'(in_ready_o), 64'd0);
        drive(r_type(7'b0, 5'd2, 5'd1, 3'd0, 5'd6, 7'b0110011), 64'd66, 64'd6);
        flush_i = 1'b1;
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        check("fl_valid", 64'(out_valid_o), 64'd0);
        check("fl_ready", 64'(in_ready_o), 64'd1);
        out_ready_i = 1'b1;
        tick();
        check("fl_no_ghost", 64'(out_valid_o), 64'd0);

        // Flush while empty: the presented input is discarded
        drive(r_type(7'b0, 5'd2, 5'd1, 3'd0, 5'd7, 7'b0110011), 64'd77, 64'd7);
        flush_i = 1'b1;
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        check("fl_empty_valid", 64'(out_valid_o), 64'd0);
        tick();
        check("fl_empty_after", 64'(out_valid_o), 64'd0);

        // Asynchronous reset mid-stall
        out_ready_i = 1'b0;
        drive(r_type(7'b0, 5'd2, 5'd1, 3'd0, 5'd8, 7'b0110011), 64'd88, 64'd8);
        tick();
        drive(r_type(7'b0, 5'd2, 5'd1, 3'd0, 5'd9, 7'b0110011), 64'd99, 64'd9);
        tick();
        in_valid_i = 1'b0;
        check("ar_pre_valid", 64'(out_valid_o), 64'd1);
        check("ar_pre_ready", 64'(in_ready_o), 64'd0);
        #2;
        rstn_i = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid_o), 64'd0);
        check("ar_ready", 64'(in_ready_o), 64'd1);
        check("ar_rs1",   data_rs1_o, 64'd0);
        check("ar_rs2",   data_rs2_o, 64'd0);
        check("ar_rd",    64'(rd_addr_o), 64'd0);
        tick();
        rstn_i      = 1'b1;
        out_ready_i = 1'b1;
        tick();
        check("ar_after_valid", 64'(out_valid_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
